// File: rtl/uart_hex_line_receiver.sv
// UART ASCII-hex line receiver: collects hex digits into a staging word with backspace,
// terminator commit, error reporting and an optional inter-character timeout.

module UART_RX #(
  parameter int CLOCK_RATE = 100_000_000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic       clk,
  input  logic       rx,
  output logic       UART_RX_Ready_Out,
  output logic [7:0] UART_RX_Data_Out
);
  localparam int CPB  = (CLOCK_RATE / BAUD_RATE < 2) ? 2 : CLOCK_RATE / BAUD_RATE;
  localparam int CNTW = $clog2(CPB);
  localparam logic [CNTW-1:0] HALF_M1 = CNTW'(CPB / 2 - 1);
  localparam logic [CNTW-1:0] FULL_M1 = CNTW'(CPB - 1);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  logic [1:0]      sync_r;
  rx_state_t       state_r, state_s;
  logic [CNTW-1:0] clk_cnt_r, clk_cnt_s;
  logic [2:0]      bit_idx_r, bit_idx_s;
  logic [7:0]      shift_r, shift_s;
  logic [7:0]      data_r, data_s;
  logic            ready_r, ready_s;
  logic            rx_s;

  assign rx_s = sync_r[1];

  // State register; no reset, so every state recovers on its own once the line idles high
  always_ff @(posedge clk) begin
    sync_r    <= {sync_r[0], rx};
    state_r   <= state_s;
    clk_cnt_r <= clk_cnt_s;
    bit_idx_r <= bit_idx_s;
    shift_r   <= shift_s;
    data_r    <= data_s;
    ready_r   <= ready_s;
  end

  // Frame decoder: start bit re-checked mid-bit, data sampled mid-bit, framing errors dropped
  always_comb begin
    state_s   = state_r;
    clk_cnt_s = clk_cnt_r;
    bit_idx_s = bit_idx_r;
    shift_s   = shift_r;
    data_s    = data_r;
    ready_s   = 1'b0;
    case (state_r)
      RX_IDLE: begin
        clk_cnt_s = '0;
        bit_idx_s = 3'd0;
        if (!rx_s) state_s = RX_START;
        else       state_s = RX_IDLE;
      end
      RX_START: begin
        if (clk_cnt_r >= HALF_M1) begin
          clk_cnt_s = '0;
          if (!rx_s) state_s = RX_DATA;
          else       state_s = RX_IDLE;
        end else begin
          clk_cnt_s = clk_cnt_r + 1'b1;
        end
      end
      RX_DATA: begin
        if (clk_cnt_r >= FULL_M1) begin
          clk_cnt_s = '0;
          shift_s   = {rx_s, shift_r[7:1]};
          if (bit_idx_r == 3'd7) state_s = RX_STOP;
          else                   bit_idx_s = bit_idx_r + 3'd1;
        end else begin
          clk_cnt_s = clk_cnt_r + 1'b1;
        end
      end
      RX_STOP: begin
        if (clk_cnt_r >= FULL_M1) begin
          clk_cnt_s = '0;
          state_s   = RX_IDLE;
          if (rx_s) begin
            data_s  = shift_r;
            ready_s = 1'b1;
          end else begin
            ready_s = 1'b0;
          end
        end else begin
          clk_cnt_s = clk_cnt_r + 1'b1;
        end
      end
      default: state_s = RX_IDLE;
    endcase
  end

  assign UART_RX_Ready_Out = ready_r;
  assign UART_RX_Data_Out  = data_r;
endmodule

module uart_hex_line_receiver #(
  parameter int CLOCK_RATE     = 100_000_000,
  parameter int BAUD_RATE      = 9600,
  parameter int DIGIT_COUNT    = 4,
  parameter int FILL_MODE      = 1,
  parameter int AUTO_COMMIT    = 1,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             RsRx,
  output logic [DIGIT_COUNT*4-1:0]         out,
  output logic                             ready_out,
  output logic [$clog2(DIGIT_COUNT+1)-1:0] digit_cnt,
  output logic                             err_out,
  output logic [1:0]                       err_code
);
  localparam int W  = DIGIT_COUNT * 4;
  localparam int CW = $clog2(DIGIT_COUNT + 1);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DIGIT_COUNT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  function automatic logic is_hex(input logic [7:0] c);
    is_hex = (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) ||
             (c >= 8'h61 && c <= 8'h66);
  endfunction

  // Letters of either case share the low nibble 1..6, so +9 maps them to A..F
  function automatic logic [3:0] hex_nib(input logic [7:0] c);
    if (c <= 8'h39) hex_nib = c[3:0];
    else            hex_nib = c[3:0] + 4'd9;
  endfunction

  function automatic logic is_term(input logic [7:0] c);
    is_term = (c == 8'h0D) || (c == 8'h0A);
  endfunction

  function automatic logic is_bs(input logic [7:0] c);
    is_bs = (c == 8'h08) || (c == 8'h7F);
  endfunction

  logic          rx_valid_s;
  logic [7:0]    rx_data_s;
  state_t        state_r, state_s;
  logic [W-1:0]  staging_r, staging_s, staging_add_s, staging_bs_s;
  logic [CW-1:0] cnt_r, cnt_s, cnt_inc_s, cnt_dec_s;
  logic [W-1:0]  out_r, out_s;
  logic          ready_r, ready_s, err_r, err_s;
  logic [1:0]    code_r, code_s;
  logic [TW-1:0] timer_r, timer_s;

  UART_RX #(
    .CLOCK_RATE(CLOCK_RATE),
    .BAUD_RATE (BAUD_RATE)
  ) u_uart_rx (
    .clk              (clk),
    .rx               (RsRx),
    .UART_RX_Ready_Out(rx_valid_s),
    .UART_RX_Data_Out (rx_data_s)
  );

  // State and output registers; a byte arriving during reset is lost
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      staging_r <= '0;
      cnt_r     <= '0;
      out_r     <= '0;
      ready_r   <= 1'b0;
      err_r     <= 1'b0;
      code_r    <= 2'd0;
      timer_r   <= '0;
    end else begin
      state_r   <= state_s;
      staging_r <= staging_s;
      cnt_r     <= cnt_s;
      out_r     <= out_s;
      ready_r   <= ready_s;
      err_r     <= err_s;
      code_r    <= code_s;
      timer_r   <= timer_s;
    end
  end

  // Line editor: byte classification, commit/discard decisions and the idle timer
  always_comb begin
    state_s   = state_r;
    staging_s = staging_r;
    cnt_s     = cnt_r;
    out_s     = out_r;
    ready_s   = 1'b0;
    err_s     = 1'b0;
    code_s    = code_r;
    timer_s   = timer_r;
    cnt_inc_s = cnt_r + 1'b1;
    cnt_dec_s = cnt_r - 1'b1;
    if (FILL_MODE != 0) begin
      staging_add_s = W'({staging_r, hex_nib(rx_data_s)});
      staging_bs_s  = staging_r >> 4;
    end else begin
      staging_add_s = staging_r | (W'(hex_nib(rx_data_s)) << {cnt_r, 2'b00});
      staging_bs_s  = staging_r & ~(W'(4'hF) << {cnt_dec_s, 2'b00});
    end

    if (rx_valid_s) begin
      timer_s = '0;
      if (is_hex(rx_data_s)) begin
        if (state_r == ST_FULL) begin
          staging_s = '0;
          cnt_s     = '0;
          err_s     = 1'b1;
          code_s    = 2'd2;
          state_s   = ST_IDLE;
        end else if (cnt_inc_s == CNT_MAX) begin
          if (AUTO_COMMIT != 0) begin
            out_s     = staging_add_s;
            ready_s   = 1'b1;
            staging_s = '0;
            cnt_s     = '0;
            state_s   = ST_IDLE;
          end else begin
            staging_s = staging_add_s;
            cnt_s     = cnt_inc_s;
            state_s   = ST_FULL;
          end
        end else begin
          staging_s = staging_add_s;
          cnt_s     = cnt_inc_s;
          state_s   = ST_COLLECT;
        end
      end else if (is_term(rx_data_s)) begin
        if (state_r != ST_IDLE) begin
          out_s     = staging_r;
          ready_s   = 1'b1;
          staging_s = '0;
          cnt_s     = '0;
          state_s   = ST_IDLE;
        end else begin
          state_s = ST_IDLE;
        end
      end else if (is_bs(rx_data_s)) begin
        if (state_r != ST_IDLE) begin
          staging_s = staging_bs_s;
          cnt_s     = cnt_dec_s;
          state_s   = (cnt_dec_s == '0) ? ST_IDLE : ST_COLLECT;
        end else begin
          state_s = ST_IDLE;
        end
      end else begin
        staging_s = '0;
        cnt_s     = '0;
        err_s     = 1'b1;
        code_s    = 2'd1;
        state_s   = ST_IDLE;
      end
    end else if (state_r != ST_IDLE && TIMEOUT_CYCLES != 0) begin
      if (timer_r == TMO_LAST) begin
        staging_s = '0;
        cnt_s     = '0;
        err_s     = 1'b1;
        code_s    = 2'd3;
        state_s   = ST_IDLE;
        timer_s   = '0;
      end else begin
        timer_s = timer_r + 1'b1;
      end
    end else begin
      timer_s = '0;
    end
  end

  assign out       = out_r;
  assign ready_out = ready_r;
  assign digit_cnt = cnt_r;
  assign err_out   = err_r;
  assign err_code  = code_r;
endmodule

// File: tb/tb_uart_hex_line_receiver.sv
// Randomized bench: two receiver configurations share one serial line and are checked
// against a digit-list reference model after every byte.

module tb_uart_hex_line_receiver;
  localparam int CR  = 80;
  localparam int BR  = 10;
  localparam int CPB = CR / BR;
  localparam int DC  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        rsrx;
  logic [15:0] out_a, out_b;
  logic        ready_a, ready_b, err_a, err_b;
  logic [2:0]  cnt_a, cnt_b;
  logic [1:0]  code_a, code_b;

  always #5 clk = ~clk;

  uart_hex_line_receiver #(
    .CLOCK_RATE(CR), .BAUD_RATE(BR), .DIGIT_COUNT(DC),
    .FILL_MODE(1), .AUTO_COMMIT(1), .TIMEOUT_CYCLES(1000)
  ) dut_a (
    .clk(clk), .reset(reset), .RsRx(rsrx), .out(out_a), .ready_out(ready_a),
    .digit_cnt(cnt_a), .err_out(err_a), .err_code(code_a)
  );

  uart_hex_line_receiver #(
    .CLOCK_RATE(CR), .BAUD_RATE(BR), .DIGIT_COUNT(DC),
    .FILL_MODE(0), .AUTO_COMMIT(0), .TIMEOUT_CYCLES(0)
  ) dut_b (
    .clk(clk), .reset(reset), .RsRx(rsrx), .out(out_b), .ready_out(ready_b),
    .digit_cnt(cnt_b), .err_out(err_b), .err_code(code_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int rdy_seen_a = 0, rdy_seen_b = 0, err_seen_a = 0, err_seen_b = 0, overlap = 0;

  // Pulse counters observed on the DUT outputs
  always @(posedge clk) begin
    if (ready_a) rdy_seen_a <= rdy_seen_a + 1;
    if (ready_b) rdy_seen_b <= rdy_seen_b + 1;
    if (err_a)   err_seen_a <= err_seen_a + 1;
    if (err_b)   err_seen_b <= err_seen_b + 1;
    if ((ready_a && err_a) || (ready_b && err_b)) overlap <= overlap + 1;
  end

  // Reference model: each line is a list of digit values in arrival order
  int          m_fill[2] = '{1, 0};
  int          m_auto[2] = '{1, 0};
  int          m_tmo[2]  = '{1000, 0};
  int          m_len[2];
  int          m_dig[2][DC];
  logic [63:0] m_out[2];
  int          m_code[2], m_rdy[2], m_err[2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int char_kind(input logic [7:0] c);
    if ((c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (c >= "a" && c <= "f")) return 0;
    if (c == 8'h0D || c == 8'h0A) return 1;
    if (c == 8'h08 || c == 8'h7F) return 2;
    return 3;
  endfunction

  function automatic int digit_val(input logic [7:0] c);
    if (c <= "9") return int'(c) - 48;
    if (c <= "F") return int'(c) - 55;
    return int'(c) - 87;
  endfunction

  function automatic logic [63:0] model_word(input int i);
    logic [63:0] v = 64'd0;
    for (int k = 0; k < m_len[i]; k++) begin
      if (m_fill[i] != 0) v = (v * 16) + 64'(m_dig[i][k]);
      else                v = v + (64'(m_dig[i][k]) << (4 * k));
    end
    return v;
  endfunction

  task automatic model_commit(input int i);
    m_out[i] = model_word(i);
    m_rdy[i]++;
    m_len[i] = 0;
  endtask

  task automatic model_error(input int i, input int code);
    m_err[i]++;
    m_code[i] = code;
    m_len[i]  = 0;
  endtask

  task automatic model_byte(input logic [7:0] c);
    for (int i = 0; i < 2; i++) begin
      case (char_kind(c))
        0: begin
          if (m_len[i] == DC) model_error(i, 2);
          else begin
            m_dig[i][m_len[i]] = digit_val(c);
            m_len[i]++;
            if (m_len[i] == DC && m_auto[i] != 0) model_commit(i);
          end
        end
        1: if (m_len[i] > 0) model_commit(i);
        2: if (m_len[i] > 0) m_len[i]--;
        default: model_error(i, 1);
      endcase
    end
  endtask

  task automatic model_timeout();
    for (int i = 0; i < 2; i++)
      if (m_tmo[i] > 0 && m_len[i] > 0) model_error(i, 3);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_len[i] = 0; m_out[i] = 64'd0; m_code[i] = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] c);
    @(negedge clk);
    rsrx = 1'b0;
    idle(CPB);
    for (int b = 0; b < 8; b++) begin
      rsrx = c[b];
      idle(CPB);
    end
    rsrx = 1'b1;
    idle(CPB);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_a_out"},  out_a,      m_out[0]);
    check({tag, "_a_cnt"},  cnt_a,      m_len[0]);
    check({tag, "_a_code"}, code_a,     m_code[0]);
    check({tag, "_a_rdy"},  rdy_seen_a, m_rdy[0]);
    check({tag, "_a_err"},  err_seen_a, m_err[0]);
    check({tag, "_b_out"},  out_b,      m_out[1]);
    check({tag, "_b_cnt"},  cnt_b,      m_len[1]);
    check({tag, "_b_code"}, code_b,     m_code[1]);
    check({tag, "_b_rdy"},  rdy_seen_b, m_rdy[1]);
    check({tag, "_b_err"},  err_seen_b, m_err[1]);
  endtask

  // Long gaps (over 1000 idle cycles) let instance A time out a pending line
  task automatic send_chk(input logic [7:0] c, input int gap, input string tag);
    send_byte(c);
    idle(gap);
    model_byte(c);
    if (gap > 500) model_timeout();
    check_state(tag);
  endtask

  task automatic send_str(input string s, input string tag);
    for (int k = 0; k < s.len(); k++) send_chk(s[k], 10, tag);
  endtask

  initial begin
    logic [7:0] c;
    string      hexs = "0123456789ABCDEFabcdef";
    int         r, gap;
    for (int i = 0; i < 2; i++) begin
      m_rdy[i] = 0; m_err[i] = 0;
    end
    model_reset();
    rsrx  = 1'b1;
    reset = 1'b1;
    idle(10);
    reset = 1'b0;
    idle(5);
    check("rst_out_a", out_a, 64'd0);
    check("rst_cnt_b", cnt_b, 64'd0);
    check_state("reset");

    send_str("1A2F", "d1a2f");
    check("dir_a_1a2f", out_a, 64'h1A2F);
    check("dir_b_full", cnt_b, 64'd4);
    send_chk(8'h0D, 10, "dterm");
    check("dir_b_f2a1", out_b, 64'hF2A1);
    send_str("beef", "dbeef");
    check("dir_a_beef", out_a, 64'hBEEF);
    send_str("12", "d12");
    send_chk(8'h0D, 10, "d12t");
    check("dir_a_0012", out_a, 64'h0012);
    send_str("12", "dbs");
    send_chk(8'h08, 10, "dbs");
    send_str("3", "dbs");
    send_chk(8'h0D, 10, "dbs");
    check("dir_a_0013", out_a, 64'h0013);
    send_chk(8'h0D, 10, "dlone_t");
    send_chk(8'h08, 10, "dlone_b");
    send_str("1G", "dbad");
    check("dir_a_bad", code_a, 64'd1);
    send_chk("7", 1200, "dtmo");
    check("dir_a_tmo", code_a, 64'd3);
    check("dir_b_hold", cnt_b, 64'd1);

    send_chk("7", 10, "dmid");
    @(negedge clk);
    reset = 1'b1;
    idle(3);
    check("mid_rst_out", out_a | out_b, 64'd0);
    check("mid_rst_cnt", cnt_a | cnt_b, 64'd0);
    check("mid_rst_code", code_a | code_b, 64'd0);
    reset = 1'b0;
    model_reset();
    idle(5);
    check_state("mid_rst");

    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 99);
      if (r < 55) c = hexs[$urandom_range(0, 21)];
      else if (r < 65) c = ($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A;
      else if (r < 75) c = ($urandom_range(0, 1) == 0) ? 8'h08 : 8'h7F;
      else begin
        c = 8'($urandom_range(0, 255));
        while (char_kind(c) != 3) c = 8'($urandom_range(0, 255));
      end
      gap = ($urandom_range(0, 19) == 0) ? 1200 : $urandom_range(8, 40);
      send_chk(c, gap, "rnd");
    end

    check("no_overlap", overlap, 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
